decimal_entry_to_bin: RTL

DECIMAL_ENTRY_TO_BIN -- requirements
Module: decimal_entry_to_bin

---
 rtl/decimal_entry_to_bin.sv | 107 ++++++++++
 1 files changed

// File: rtl/decimal_entry_to_bin.sv
// Keypad decimal entry: accumulates up to three BCD digits plus a sign and
// commits an 8-bit two's-complement value. Multiply-by-ten spans two cycles.
module decimal_entry_to_bin (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       neg_toggle,
    input  logic       enter,
    input  logic       clear,
    output logic [7:0] val,
    output logic       val_valid,
    output logic       neg,
    output logic [1:0] count,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL1  = 2'd1,
        MUL2  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t     state;
    logic [9:0] acc;
    logic [9:0] tmp;
    logic [3:0] dig;

    logic       commit_ok;
    logic [7:0] neg_mag;

    // Negative entries may reach one step further than positive ones (-128).
    always_comb begin
        commit_ok = neg ? (acc <= 10'd128) : (acc <= 10'd127);
        neg_mag   = 8'd0 - acc[7:0];
    end

    // NOTE: every register here is state, so all updates are non-blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            tmp       <= '0;
            dig       <= '0;
            val       <= '0;
            val_valid <= 1'b0;
            neg       <= 1'b0;
            count     <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            val_valid <= 1'b0;
            if (clear) begin
                state <= IDLE;
                acc   <= '0;
                count <= '0;
                neg   <= 1'b0;
                busy  <= 1'b0;
                err   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (neg_toggle)
                            neg <= ~neg;
                        if (digit_valid) begin
                            if (digit > 4'd9 || count == 2'd3) begin
                                state <= ERROR;
                                err   <= 1'b1;
                            end else begin
                                dig   <= digit;
                                state <= MUL1;
                                busy  <= 1'b1;
                            end
                        end else if (enter) begin
                            if (commit_ok) begin
                                val       <= neg ? neg_mag : acc[7:0];
                                val_valid <= 1'b1;
                                acc       <= '0;
                                count     <= '0;
                                neg       <= 1'b0;
                            end else begin
                                state <= ERROR;
                                err   <= 1'b1;
                            end
                        end
                    end
                    MUL1: begin
                        // acc is at most 99 here, so acc*8 still fits 10 bits.
                        tmp   <= acc << 3;
                        state <= MUL2;
                    end
                    MUL2: begin
                        acc   <= tmp + (acc << 1) + {6'd0, dig};
                        count <= count + 2'd1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    ERROR: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
